gray_counter: RTL and testbench

//   Parametrised up/down counter that keeps a binary and a Gray-coded value in lockstep.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_counter_next.sv | 61 ++++++
 rtl/gray_counter.sv | 85 ++++++++
 tb/tb_gray_counter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared binary/Gray conversion helpers
package gray_pkg;

    // Widest counter the helpers support; callers zero-extend to this width
    // and cast the result back down to their own width.
    localparam int unsigned GRAY_MAX_W = 32;

    // Gray code of a binary value: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary value of a Gray code: b[i] is the XOR of all Gray bits from i upward.
    // Zero-extended upper bits contribute nothing, so this works for any width.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_next.sv
// rtl/gray_counter_next.sv - combinational next-state block for gray_counter
module gray_next
    import gray_pkg::*;
#(
    parameter int unsigned          WIDTH     = 3,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter bit                   SATURATE  = 1'b0
) (
    input  logic [WIDTH-1:0] bin_cur,
    input  logic             clr,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] bin_nxt,
    output logic [WIDTH-1:0] gray_nxt,
    output logic             wrap_nxt
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    // Command decode with priority clr > load > en; limit hits flag wrap
    // whether the value rolls over or is held by saturation.
    always_comb begin
        bin_nxt  = bin_cur;
        wrap_nxt = 1'b0;
        if (clr) begin
            bin_nxt = RESET_VAL;
        end else if (load) begin
            if (load_gray) begin
                bin_nxt = WIDTH'(gray2bin(GRAY_MAX_W'(load_val)));
            end else begin
                bin_nxt = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (bin_cur == ALL_ONES) begin
                    wrap_nxt = 1'b1;
                    bin_nxt  = SATURATE ? bin_cur : ZERO;
                end else begin
                    bin_nxt = bin_cur + WIDTH'(1);
                end
            end else begin
                if (bin_cur == ZERO) begin
                    wrap_nxt = 1'b1;
                    bin_nxt  = SATURATE ? bin_cur : ALL_ONES;
                end else begin
                    bin_nxt = bin_cur - WIDTH'(1);
                end
            end
        end
    end

    // Gray value derived from the next binary value so both register together.
    always_comb begin
        gray_nxt = WIDTH'(bin2gray(GRAY_MAX_W'(bin_nxt)));
    end

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered up/down counter with lockstep binary and Gray outputs
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned          WIDTH     = 3,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter bit                   SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] ZERO       = '0;
    localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RESET_VAL)));

    initial begin
        assert (WIDTH >= 2 && WIDTH <= GRAY_MAX_W)
            else $fatal(1, "gray_counter: WIDTH out of range");
    end

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             wrap_q,   wrap_d;

    gray_next #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .SATURATE  (SATURATE)
    ) u_next (
        .bin_cur   (bin_q),
        .clr       (clr),
        .load      (load),
        .load_gray (load_gray),
        .load_val  (load_val),
        .en        (en),
        .up_dn     (up_dn),
        .bin_nxt   (bin_d),
        .gray_nxt  (gray_d),
        .wrap_nxt  (wrap_d)
    );

    // Limit flags come from the next binary value so they register alongside it.
    always_comb begin
        at_max_d = (bin_d == ALL_ONES);
        at_min_d = (bin_d == ZERO);
    end

    // All outputs are flops; reset drops them to the reset value at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= RESET_VAL;
            gray_q   <= RESET_GRAY;
            at_max_q <= (RESET_VAL == ALL_ONES);
            at_min_q <= (RESET_VAL == ZERO);
            wrap_q   <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign at_max   = at_max_q;
    assign at_min   = at_min_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed and randomised checks of gray_counter
module tb_gray_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=3 wrapping instance
    logic       a_clr, a_load, a_load_gray, a_en, a_up_dn;
    logic [2:0] a_load_val, a_bin, a_gray;
    logic       a_at_max, a_at_min, a_wrap;

    // WIDTH=3 saturating instance
    logic       s_clr, s_load, s_load_gray, s_en, s_up_dn;
    logic [2:0] s_load_val, s_bin, s_gray;
    logic       s_at_max, s_at_min, s_wrap;

    // WIDTH=8 wrapping instance
    logic       e_clr, e_load, e_load_gray, e_en, e_up_dn;
    logic [7:0] e_load_val, e_bin, e_gray;
    logic       e_at_max, e_at_min, e_wrap;

    gray_counter #(.WIDTH(3), .RESET_VAL(3'd0), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_gray(a_load_gray),
        .load_val(a_load_val), .en(a_en), .up_dn(a_up_dn), .bin_out(a_bin),
        .gray_out(a_gray), .at_max(a_at_max), .at_min(a_at_min), .wrap(a_wrap)
    );

    gray_counter #(.WIDTH(3), .RESET_VAL(3'd0), .SATURATE(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .load(s_load), .load_gray(s_load_gray),
        .load_val(s_load_val), .en(s_en), .up_dn(s_up_dn), .bin_out(s_bin),
        .gray_out(s_gray), .at_max(s_at_max), .at_min(s_at_min), .wrap(s_wrap)
    );

    gray_counter #(.WIDTH(8), .RESET_VAL(8'd0), .SATURATE(1'b0)) u_e (
        .clk(clk), .rst_n(rst_n), .clr(e_clr), .load(e_load), .load_gray(e_load_gray),
        .load_val(e_load_val), .en(e_en), .up_dn(e_up_dn), .bin_out(e_bin),
        .gray_out(e_gray), .at_max(e_at_max), .at_min(e_at_min), .wrap(e_wrap)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] g_exp [8];
    logic [2:0] prev_g;
    logic [7:0] m_bin, m_nxt, m_g;
    logic       m_wrap;

    initial begin
        g_exp = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

        rst_n = 1'b0;
        {a_clr, a_load, a_load_gray, a_en, a_up_dn} = '0; a_load_val = '0;
        {s_clr, s_load, s_load_gray, s_en, s_up_dn} = '0; s_load_val = '0;
        {e_clr, e_load, e_load_gray, e_en, e_up_dn} = '0; e_load_val = '0;
        tick();
        tick();
        check("rst_bin",    32'(a_bin),    32'd0);
        check("rst_gray",   32'(a_gray),   32'd0);
        check("rst_at_min", 32'(a_at_min), 32'd1);
        check("rst_at_max", 32'(a_at_max), 32'd0);
        check("rst_wrap",   32'(a_wrap),   32'd0);
        rst_n = 1'b1;

        // 1: asynchronous reset in the middle of a count
        a_en = 1'b1; a_up_dn = 1'b1;
        repeat (5) tick();
        check("t1_bin5", 32'(a_bin), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t1_bin",    32'(a_bin),    32'd0);
        check("t1_gray",   32'(a_gray),   32'd0);
        check("t1_at_min", 32'(a_at_min), 32'd1);
        check("t1_wrap",   32'(a_wrap),   32'd0);
        a_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_hold", 32'(a_bin), 32'd0);

        // 2: full up sequence from zero
        a_en = 1'b1; a_up_dn = 1'b1;
        prev_g = a_gray;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t2_gray%0d", i), 32'(a_gray), 32'(g_exp[i]));
            check($sformatf("t2_wrap%0d", i), 32'(a_wrap), (i == 7) ? 32'd1 : 32'd0);
            check($sformatf("t2_step%0d", i), 32'($countones(prev_g ^ a_gray)), 32'd1);
            prev_g = a_gray;
        end

        // 3: down from zero wraps to all-ones
        a_up_dn = 1'b0;
        tick();
        check("t3_bin",    32'(a_bin),    32'd7);
        check("t3_gray",   32'(a_gray),   32'd4);
        check("t3_at_max", 32'(a_at_max), 32'd1);
        check("t3_wrap",   32'(a_wrap),   32'd1);
        tick();
        check("t3_bin6",   32'(a_bin),    32'd6);
        check("t3_wrap0",  32'(a_wrap),   32'd0);
        a_en = 1'b0;

        // 4: Gray load, clr beating load, binary load, hold
        a_load = 1'b1; a_load_gray = 1'b1; a_load_val = 3'b101; a_en = 1'b1;
        tick();
        check("t4_bin",  32'(a_bin),  32'd6);
        check("t4_gray", 32'(a_gray), 32'd5);
        check("t4_wrap", 32'(a_wrap), 32'd0);
        a_clr = 1'b1;
        tick();
        check("t4_clr_bin",  32'(a_bin),    32'd0);
        check("t4_clr_min",  32'(a_at_min), 32'd1);
        a_clr = 1'b0; a_load_gray = 1'b0; a_load_val = 3'd3;
        tick();
        check("t4_ldb_bin",  32'(a_bin),  32'd3);
        check("t4_ldb_gray", 32'(a_gray), 32'd2);
        a_load = 1'b0; a_en = 1'b0;
        tick();
        check("t4_hold_bin",  32'(a_bin),  32'd3);
        check("t4_hold_wrap", 32'(a_wrap), 32'd0);

        // 5: saturating instance at both limits
        s_load = 1'b1; s_load_val = 3'd7;
        tick();
        s_load = 1'b0; s_en = 1'b1; s_up_dn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_bin%0d", i),  32'(s_bin),  32'd7);
            check($sformatf("t5_gray%0d", i), 32'(s_gray), 32'd4);
            check($sformatf("t5_wrap%0d", i), 32'(s_wrap), 32'd1);
        end
        s_up_dn = 1'b0;
        tick();
        check("t5_dn_bin",  32'(s_bin),  32'd6);
        check("t5_dn_wrap", 32'(s_wrap), 32'd0);
        s_en = 1'b0; s_load = 1'b1; s_load_val = 3'd0;
        tick();
        s_load = 1'b0; s_en = 1'b1;
        tick();
        check("t5_lo_bin",  32'(s_bin),    32'd0);
        check("t5_lo_wrap", 32'(s_wrap),   32'd1);
        check("t5_lo_min",  32'(s_at_min), 32'd1);
        s_en = 1'b0;

        // 6: random traffic on the 8-bit instance against a reference model
        m_bin = 8'd0;
        for (int c = 0; c < 3000; c++) begin
            e_clr       = ($urandom_range(0, 31) == 0);
            e_load      = ($urandom_range(0, 15) == 0);
            e_load_gray = $urandom_range(0, 1) == 1;
            e_load_val  = 8'($urandom);
            e_en        = ($urandom_range(0, 3) != 0);
            e_up_dn     = ($urandom_range(0, 2) != 0);
            m_nxt  = m_bin;
            m_wrap = 1'b0;
            if (e_clr) begin
                m_nxt = 8'd0;
            end else if (e_load) begin
                if (e_load_gray) begin
                    m_nxt[7] = e_load_val[7];
                    for (int i = 6; i >= 0; i--) m_nxt[i] = m_nxt[i+1] ^ e_load_val[i];
                end else begin
                    m_nxt = e_load_val;
                end
            end else if (e_en) begin
                if (e_up_dn) begin
                    m_wrap = (m_bin == 8'hff);
                    m_nxt  = m_bin + 8'd1;
                end else begin
                    m_wrap = (m_bin == 8'h00);
                    m_nxt  = m_bin - 8'd1;
                end
            end
            m_bin = m_nxt;
            m_g   = m_bin ^ (m_bin >> 1);
            tick();
            check("t6_bin",    32'(e_bin),    32'(m_bin));
            check("t6_gray",   32'(e_gray),   32'(m_g));
            check("t6_wrap",   32'(e_wrap),   32'(m_wrap));
            check("t6_at_max", 32'(e_at_max), 32'(m_bin == 8'hff));
            check("t6_at_min", 32'(e_at_min), 32'(m_bin == 8'h00));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
